multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_alu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multi-cycle signed ALU with register-file writeback
//
// Purpose: executes one ADD/SUB/MUL/DIV per request on 16-bit signed operands.
//   ADD/SUB finish in one EXEC cycle; MUL (shift-add) and DIV (restoring) take
//   16 EXEC cycles. The result is presented for one WB cycle as a register-file
//   write strobe.
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset
//   start           request a new operation (sampled only in IDLE)
//   opcode          00 ADD, 01 SUB, 10 MUL, 11 DIV
//   operand_a/_b    signed 16-bit operands
//   dest_index      destination register index
//   busy            high whenever not IDLE
//   write_enable    one-cycle register-file write strobe (WB)
//   write_reg_index register-file write index
//   write_data      signed 16-bit result
//   div_by_zero     error flag, valid with write_enable

module multicycle_alu (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic signed [15:0] operand_a,
  input  logic signed [15:0] operand_b,
  input  logic [1:0]         dest_index,
  output logic               busy,
  output logic               write_enable,
  output logic [1:0]         write_reg_index,
  output logic signed [15:0] write_data,
  output logic               div_by_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t state_q, state_d;

  // Latched request
  logic [1:0]         op_q;
  logic signed [15:0] a_q, b_q;
  logic [1:0]         dest_q;
  logic               neg_q;       // sign(a) ^ sign(b)
  logic [3:0]         cnt_q;

  // Multiplier: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [16:0]        acc_q, mcand_q;
  logic [15:0]        mplier_q;

  // Divider: partial remainder, dividend/quotient shift register, divisor
  logic [16:0]        rem_q, divisor_q;
  logic [15:0]        quot_q;

  // Registered writeback values
  logic [15:0]        res_q;
  logic [1:0]         widx_q;
  logic               dbz_q;

  // Magnitudes of the incoming operands; -32768 maps to 17'h08000
  logic [16:0] mag_in_a, mag_in_b;
  always_comb begin
    mag_in_a = operand_a[15] ? (17'd0 - {1'b1, operand_a}) : {1'b0, operand_a};
    mag_in_b = operand_b[15] ? (17'd0 - {1'b1, operand_b}) : {1'b0, operand_b};
  end

  // One iteration of each iterative unit
  logic [16:0] acc_nxt;
  logic [17:0] rem_sh;
  logic        rem_ge;
  logic [16:0] rem_nxt;
  logic [15:0] quot_nxt;

  always_comb begin
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : 17'd0);
    rem_sh   = {rem_q, quot_q[15]};
    rem_ge   = rem_sh >= {1'b0, divisor_q};
    rem_nxt  = rem_ge ? 17'(rem_sh - {1'b0, divisor_q}) : rem_sh[16:0];
    quot_nxt = {quot_q[14:0], rem_ge};
  end

  // Single-cycle ops and divide-by-zero bypass the iterative units
  logic is_dbz, last_exec;
  always_comb begin
    is_dbz    = (op_q == OP_DIV) && (b_q == 16'sd0);
    last_exec = (op_q == OP_ADD) || (op_q == OP_SUB) || is_dbz || (cnt_q == 4'd15);
  end

  // Result as seen at the final EXEC edge (uses the last iteration's values)
  logic [15:0] result_c;
  always_comb begin
    result_c = 16'd0;
    case (op_q)
      OP_ADD: result_c = a_q + b_q;
      OP_SUB: result_c = a_q - b_q;
      OP_MUL: result_c = neg_q ? (16'd0 - acc_nxt[15:0]) : acc_nxt[15:0];
      OP_DIV: result_c = is_dbz ? 16'd0 : (neg_q ? (16'd0 - quot_nxt) : quot_nxt);
      default: result_c = 16'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EXEC;
      EXEC:    if (last_exec) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy            = (state_q != IDLE);
    write_enable    = (state_q == WB);
    div_by_zero     = (state_q == WB) && dbz_q;
    write_reg_index = widx_q;
    write_data      = res_q;
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 2'd0;
      a_q       <= 16'sd0;
      b_q       <= 16'sd0;
      dest_q    <= 2'd0;
      neg_q     <= 1'b0;
      cnt_q     <= 4'd0;
      acc_q     <= 17'd0;
      mcand_q   <= 17'd0;
      mplier_q  <= 16'd0;
      rem_q     <= 17'd0;
      divisor_q <= 17'd0;
      quot_q    <= 16'd0;
      res_q     <= 16'd0;
      widx_q    <= 2'd0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= opcode;
            a_q       <= operand_a;
            b_q       <= operand_b;
            dest_q    <= dest_index;
            neg_q     <= operand_a[15] ^ operand_b[15];
            cnt_q     <= 4'd0;
            acc_q     <= 17'd0;
            mcand_q   <= mag_in_a;
            mplier_q  <= mag_in_b[15:0];
            rem_q     <= 17'd0;
            divisor_q <= mag_in_b;
            quot_q    <= mag_in_a[15:0];
          end
        end
        EXEC: begin
          cnt_q    <= cnt_q + 4'd1;
          acc_q    <= acc_nxt;
          mcand_q  <= {mcand_q[15:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[15:1]};
          rem_q    <= rem_nxt;
          quot_q   <= quot_nxt;
          if (last_exec) begin
            res_q  <= result_c;
            widx_q <= dest_q;
            dbz_q  <= is_dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu
module tb_multicycle_alu;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         opcode;
  logic signed [15:0] operand_a, operand_b;
  logic [1:0]         dest_index;
  logic               busy, write_enable, div_by_zero;
  logic [1:0]         write_reg_index;
  logic signed [15:0] write_data;

  int compared = 0;
  int mismatched = 0;

  multicycle_alu dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .dest_index(dest_index),
    .busy(busy), .write_enable(write_enable), .write_reg_index(write_reg_index),
    .write_data(write_data), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [1:0]  dest;
    logic [15:0] exp_d;
    logic        exp_z;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic, low 16 bits kept
  function automatic void model(input logic [1:0] op, input logic signed [15:0] a,
                                input logic signed [15:0] b, output logic [15:0] d,
                                output logic z, output int lat);
    int ia, ib, r;
    ia = a; ib = b; z = 1'b0; lat = 1; r = 0;
    case (op)
      2'b00: r = ia + ib;
      2'b01: r = ia - ib;
      2'b10: begin r = ia * ib; lat = 16; end
      default: begin
        if (ib == 0) begin r = 0; z = 1'b1; end
        else begin r = ia / ib; lat = 16; end
      end
    endcase
    d = r[15:0];
  endfunction

  // Issue one op; with hold=1, start stays high with fresh operands through EXEC and WB
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] d, input logic [15:0] exp_d, input logic exp_z,
                        input int exp_lat, input bit hold);
    int n;
    @(negedge clk);
    start = 1'b1; opcode = op; operand_a = a; operand_b = b; dest_index = d;
    @(posedge clk); #1;
    check("busy_accept", {31'd0, busy}, 32'd1);
    start = hold;
    opcode = 2'($urandom); operand_a = 16'($urandom);
    operand_b = 16'($urandom); dest_index = 2'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!write_enable && n < 40);
    check("latency", n, exp_lat);
    check("write_data", {16'd0, write_data}, {16'd0, exp_d});
    check("write_idx", {30'd0, write_reg_index}, {30'd0, d});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_z});
    check("busy_wb", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check("we_drop", {31'd0, write_enable}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("dbz_idle", {31'd0, div_by_zero}, 32'd0);
    check("data_hold", {16'd0, write_data}, {16'd0, exp_d});
  endtask

  vec_t vecs[10];

  initial begin
    logic [1:0]  rop, rd;
    logic [15:0] ra, rb, ed;
    logic        ez;
    int          el, we_cnt;

    vecs[0] = '{2'b00, 16'h7FFF, 16'h0001, 2'd2, 16'h8000, 1'b0, 1};
    vecs[1] = '{2'b01, 16'h0000, 16'h0001, 2'd3, 16'hFFFF, 1'b0, 1};
    vecs[2] = '{2'b10, 16'hFFF9, 16'd300,  2'd1, 16'hF7CC, 1'b0, 16};
    vecs[3] = '{2'b10, 16'd300,  16'd300,  2'd0, 16'h5F90, 1'b0, 16};
    vecs[4] = '{2'b11, 16'hFFF9, 16'd2,    2'd1, 16'hFFFD, 1'b0, 16};
    vecs[5] = '{2'b11, 16'd7,    16'hFFFE, 2'd2, 16'hFFFD, 1'b0, 16};
    vecs[6] = '{2'b11, 16'h8000, 16'hFFFF, 2'd3, 16'h8000, 1'b0, 16};
    vecs[7] = '{2'b11, 16'd5,    16'd0,    2'd0, 16'h0000, 1'b1, 1};
    vecs[8] = '{2'b10, 16'h8000, 16'hFFFF, 2'd1, 16'h8000, 1'b0, 16};
    vecs[9] = '{2'b11, 16'd100,  16'd7,    2'd2, 16'h000E, 1'b0, 16};

    // Reset with start held high: must not be accepted
    reset = 1'b1; start = 1'b1; opcode = 2'b00;
    operand_a = 16'sd1; operand_b = 16'sd1; dest_index = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_idx", {30'd0, write_reg_index}, 32'd0);
    check("rst_data", {16'd0, write_data}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    // Directed vectors
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
             vecs[i].exp_d, vecs[i].exp_z, vecs[i].exp_lat, 1'b0);

    // start re-asserted with new operands during MUL EXEC and WB
    run_op(2'b10, 16'hFFF9, 16'd300, 2'd1, 16'hF7CC, 1'b0, 16, 1'b1);

    // Reset pulsed at EXEC cycle 8 of a DIV
    @(negedge clk);
    start = 1'b1; opcode = 2'b11; operand_a = 16'sd1000; operand_b = 16'sd3; dest_index = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_we", {31'd0, write_enable}, 32'd0);
    check("mid_rst_data", {16'd0, write_data}, 32'd0);
    check("mid_rst_idx", {30'd0, write_reg_index}, 32'd0);
    check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    we_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (write_enable) we_cnt++;
    end
    check("post_rst_no_we", we_cnt, 0);
    run_op(2'b00, 16'd5, 16'd6, 2'd1, 16'd11, 1'b0, 1, 1'b0);

    // Randomized back-to-back ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        2: ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0: rb = 16'h0000;
        1: rb = 16'hFFFF;
        2: rb = 16'h8000;
        3: rb = 16'($urandom_range(1, 20));
        default: rb = 16'($urandom);
      endcase
      rd = 2'($urandom);
      model(rop, ra, rb, ed, ez, el);
      run_op(rop, ra, rb, rd, ed, ez, el, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
